// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: frames SPI characters between command, TX/RX word streams and a shift engine.
// Optional abort input enabled by defining SPI_XFER_CTRL_ABORT_EN.
module spi_xfer_ctrl #(
    parameter int N        = 32,
    parameter int NCS      = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic           I_CLK,
    input  logic           I_RST_N,
`ifdef SPI_XFER_CTRL_ABORT_EN
    input  logic           I_ABORT,
`endif
    input  logic           I_CMD_VALID,
    output logic           O_CMD_READY,
    input  logic [1:0]     I_CMD_CS,
    input  logic [15:0]    I_CMD_LEN,
    input  logic           I_TX_VALID,
    output logic           O_TX_READY,
    input  logic [N-1:0]   I_TX_DATA,
    output logic           O_RX_VALID,
    input  logic           I_RX_READY,
    output logic [N-1:0]   O_RX_DATA,
    output logic           O_ENG_START,
    output logic [N-1:0]   O_ENG_TX_DATA,
    input  logic           I_ENG_DONE,
    input  logic [N-1:0]   I_ENG_RX_DATA,
    output logic [NCS-1:0] O_CS,
    output logic           O_BUSY,
    output logic           O_DON
);
    typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, STORE, HOLD} state_t;
    state_t state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [15:0] rem, rem_d;
    logic [NCS-1:0] cs_d;
    logic start_d, don_d, rxv_d, abort;
    logic [N-1:0] txd_d, rxd_d;
    assign O_CMD_READY = state == IDLE;
    assign O_TX_READY  = state == LOAD;
    assign O_BUSY      = state != IDLE;
`ifdef SPI_XFER_CTRL_ABORT_EN
    logic pend;
    assign abort = I_ABORT | pend;
    // Remember an abort raised mid-character until the engine finishes it
    always_ff @(posedge I_CLK or negedge I_RST_N)
        if (!I_RST_N) pend <= 1'b0;
        else pend <= state == SHIFT && !I_ENG_DONE && abort;
`else
    assign abort = 1'b0;
`endif
    // Next-state and next-output decode
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rem_d   = rem;
        cs_d    = O_CS;
        start_d = 1'b0;
        don_d   = 1'b0;
        rxv_d   = O_RX_VALID;
        txd_d   = O_ENG_TX_DATA;
        rxd_d   = O_RX_DATA;
        case (state)
            IDLE: if (I_CMD_VALID) begin
                if (I_CMD_LEN == 16'd0) don_d = 1'b1;
                else begin
                    state_d = SETUP;
                    cnt_d   = 8'd0;
                    rem_d   = I_CMD_LEN;
                    for (int i = 0; i < NCS; i++) cs_d[i] = int'(I_CMD_CS) != i;
                end
            end
            SETUP: if (abort) begin
                state_d = HOLD;
                cnt_d   = 8'd0;
            end else if (int'(cnt) + 1 >= CS_SETUP) state_d = LOAD;
            else cnt_d = cnt + 8'd1;
            LOAD: if (abort) begin
                state_d = HOLD;
                cnt_d   = 8'd0;
            end else if (I_TX_VALID) begin
                txd_d   = I_TX_DATA;
                start_d = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: if (I_ENG_DONE) begin
                if (abort) begin
                    state_d = HOLD;
                    cnt_d   = 8'd0;
                end else begin
                    rxd_d   = I_ENG_RX_DATA;
                    rxv_d   = 1'b1;
                    state_d = STORE;
                end
            end
            STORE: if (abort) begin
                rxv_d   = 1'b0;
                state_d = HOLD;
                cnt_d   = 8'd0;
            end else if (I_RX_READY) begin
                rxv_d   = 1'b0;
                rem_d   = rem - 16'd1;
                state_d = rem == 16'd1 ? HOLD : LOAD;
                cnt_d   = 8'd0;
            end
            HOLD: if (int'(cnt) + 1 >= CS_HOLD) begin
                state_d = IDLE;
                cs_d    = '1;
                don_d   = 1'b1;
                cnt_d   = 8'd0;
            end else cnt_d = cnt + 8'd1;
            default: state_d = IDLE;
        endcase
    end
    // State and output registers; reset releases chip selects immediately
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            rem           <= 16'd0;
            O_CS          <= '1;
            O_ENG_START   <= 1'b0;
            O_DON         <= 1'b0;
            O_RX_VALID    <= 1'b0;
            O_ENG_TX_DATA <= '0;
            O_RX_DATA     <= '0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            rem           <= rem_d;
            O_CS          <= cs_d;
            O_ENG_START   <= start_d;
            O_DON         <= don_d;
            O_RX_VALID    <= rxv_d;
            O_ENG_TX_DATA <= txd_d;
            O_RX_DATA     <= rxd_d;
        end
    end
endmodule
